instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Upstream stage of the decoder: owns the PC, fetches one instruction word per step from
//  a variable-latency instruction memory, presents instr_o[31:26] to the decoder, and
//  resolves the next PC from the decoder's Branch/Branch_Type/Jump outputs plus ALU flags.
//  Drives the fetch/execute step of the single-issue core.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  TIMEOUT    8'd255         max cycles waiting for imem_valid_i before fetch_err_o
// PORTS
//  clk_i          in   1   clock, all state on rising edge
//  rst_i          in   1   synchronous reset, active-low
//  imem_req_o     out  1   fetch request, held high until imem_valid_i
//  imem_addr_o    out  32  fetch address (= pc_o)
//  imem_rdata_i   in   32  instruction word
//  imem_valid_i   in   1   rdata valid this cycle
//  instr_o        out  32  latched instruction to decoder/regfile
//  instr_valid_o  out  1   instr_o valid, core may execute
//  exec_done_i    in   1   core finished current instr; commit next PC
//  branch_i       in   1   decoder Branch
//  branch_type_i  in   2   decoder Branch_Type
//  jump_i         in   1   decoder Jump
//  zero_i         in   1   ALU zero flag
//  sign_i         in   1   ALU result[31]
//  pc_o           out  32  current PC
//  pc_plus4_o     out  32  pc_o+4 (link value for jal)
//  fetch_err_o    out  1   sticky: imem timeout
// BEHAVIOUR
//  Reset (rst_i==0 at edge): pc=RESET_PC, state=IDLE, imem_req_o=0, instr_o=0,
//   instr_valid_o=0, fetch_err_o=0, timeout counter=0. Reset mid-fetch discards the
//   outstanding request; a late imem_valid_i is ignored.
//  FSM: IDLE -> FETCH (1 cycle after reset release).
//   FETCH: imem_req_o=1, count cycles; on imem_valid_i: instr_o<=imem_rdata_i,
//     instr_valid_o<=1, -> EXEC (fetch latency = imem latency + 1 cycle).
//     Counter reaching TIMEOUT without valid: fetch_err_o<=1, -> HALT.
//   EXEC: instr_valid_o=1, imem_req_o=0; imem_valid_i ignored. On exec_done_i: pc<=next_pc,
//     instr_valid_o<=0, -> FETCH next cycle. exec_done_i outside EXEC ignored.
//   HALT: all outputs hold; leave only by reset.
//  next_pc (combinational on EXEC inputs), priority jump > branch > sequential:
//   jump_i: {pc_plus4[31:28], instr_o[25:0], 2'b00}
//   branch_i & cond: pc_plus4 + ({{14{instr_o[15]}}, instr_o[15:0], 2'b00})
//   else: pc_plus4. All adds mod 2^32 (0xFFFF_FFFC+4 wraps to 0).
//  cond by branch_type_i: 00 zero_i; 01 ~zero_i & ~sign_i (gt);
//   10 zero_i | sign_i (le); 11 ~zero_i.
//  pc[1:0] always 0; targets are word-aligned by construction.
// CONFIGURATION
//  IFU_JR_EN: adds ports jr_i (in,1) and jr_target_i (in,32); in EXEC, jr_i has highest
//   priority and next_pc = {jr_target_i[31:2],2'b00}. Without macro: ports absent, jr
//   handled nowhere in this block.
// TESTING
//  Reset: rst_i=0 two cycles, release -> pc_o=0, req rises cycle 2, instr_valid_o=0.
//  Seq: imem 3-cycle latency, exec_done after 1 cycle, no branch -> pc 0,4,8; valid each fetch.
//  beq taken: instr imm=16'hFFFE at pc 0x10, branch_i=1,type=00,zero_i=1 -> pc_o=0x0C.
//  Jump+branch same cycle: jump_i=1,branch_i=1,instr[25:0]=26'h40 -> pc_o=0x100.
//  Timeout: imem_valid_i held 0 for TIMEOUT cycles -> fetch_err_o=1, state frozen till reset.
//  Reset mid-FETCH, imem_valid_i arrives 1 cycle after reset asserted -> instr_o=0, pc_o=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches from variable-latency imem, resolves next PC on exec_done_i.
// Optional register-jump support is enabled by defining IFU_JR_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_valid_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  input  logic        exec_done_i,
  input  logic        branch_i,
  input  logic [1:0]  branch_type_i,
  input  logic        jump_i,
  input  logic        zero_i,
  input  logic        sign_i,
`ifdef IFU_JR_EN
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
`endif
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        fetch_err_o
);

  // state | meaning
  // IDLE  | one cycle after reset release, no request
  // FETCH | request held, waiting for imem_valid_i, timeout counting
  // EXEC  | instruction presented, waiting for exec_done_i
  // HALT  | imem timeout, frozen until reset
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] next_pc;
  logic [7:0]  cnt_inc;
  logic        cond;

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    unique case (branch_type_i)
      2'b00:   cond = zero_i;
      2'b01:   cond = ~zero_i & ~sign_i;
      2'b10:   cond = zero_i | sign_i;
      default: cond = ~zero_i;
    endcase
    next_pc = pc_plus4;
`ifdef IFU_JR_EN
    if (jr_i)
      next_pc = {jr_target_i[31:2], 2'b00};
    else if (jump_i)
`else
    if (jump_i)
`endif
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    else if (branch_i && cond)
      next_pc = pc_plus4 + br_off;
  end

  always_comb begin
    cnt_inc = cnt_q + 8'd1;
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    req_d   = req_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
        cnt_d   = 8'd0;
      end
      FETCH: begin
        if (imem_valid_i) begin
          instr_d = imem_rdata_i;
          valid_d = 1'b1;
          req_d   = 1'b0;
          cnt_d   = 8'd0;
          state_d = EXEC;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT) begin
            err_d   = 1'b1;
            state_d = HALT;
          end
        end
      end
      EXEC: begin
        cnt_d = 8'd0;
        if (exec_done_i) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          req_d   = 1'b1;
          state_d = FETCH;
        end
      end
      default: ;  // HALT: everything holds until reset
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4;
  assign fetch_err_o   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed and randomized fetch/execute steps checked every cycle
// against an instruction-level expectation of PC, instruction and handshake outputs.
module tb_instr_fetch_unit;

  localparam logic [7:0] TMO = 8'd20;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        imem_valid_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        exec_done_i;
  logic        branch_i;
  logic [1:0]  branch_type_i;
  logic        jump_i;
  logic        zero_i;
  logic        sign_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        fetch_err_o;
`ifdef IFU_JR_EN
  logic        jr_i = 1'b0;
  logic [31:0] jr_target_i = 32'd0;
`endif

  instr_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rdata_i(imem_rdata_i), .imem_valid_i(imem_valid_i),
    .instr_o(instr_o), .instr_valid_o(instr_valid_o),
    .exec_done_i(exec_done_i), .branch_i(branch_i), .branch_type_i(branch_type_i),
    .jump_i(jump_i), .zero_i(zero_i), .sign_i(sign_i),
`ifdef IFU_JR_EN
    .jr_i(jr_i), .jr_target_i(jr_target_i),
`endif
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .fetch_err_o(fetch_err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_pc, exp_instr;
  logic        exp_req, exp_valid, exp_err;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("pc",       pc_o,                 exp_pc);
      chk("pc_plus4", pc_plus4_o,           exp_pc + 32'd4);
      chk("addr",     imem_addr_o,          exp_pc);
      chk("req",      32'(imem_req_o),      32'(exp_req));
      chk("instr",    instr_o,              exp_instr);
      chk("valid",    32'(instr_valid_o),   32'(exp_valid));
      chk("err",      32'(fetch_err_o),     32'(exp_err));
    end
  end

  // Architectural next-PC rule, written from the instruction semantics.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                             input bit br, input logic [1:0] bt,
                                             input bit j, input bit z, input bit s);
    logic [31:0] seq;
    int          off;
    bit          take;
    seq  = pc + 32'd4;
    off  = $signed(w[15:0]) * 4;
    case (bt)
      2'd0:    take = z;
      2'd1:    take = !z && !s;
      2'd2:    take = z || s;
      default: take = !z;
    endcase
    if (j) return {seq[31:28], w[25:0], 2'b00};
    if (br && take) return seq + 32'(off);
    return seq;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rnd_ctl();
    branch_i      = 1'($urandom);
    branch_type_i = 2'($urandom);
    jump_i        = 1'($urandom);
    zero_i        = 1'($urandom);
    sign_i        = 1'($urandom);
  endtask

  task automatic reset_exp();
    exp_pc = 32'h0; exp_instr = 32'h0;
    exp_req = 1'b0; exp_valid = 1'b0; exp_err = 1'b0;
  endtask

  // One full fetch/execute: lat idle imem cycles, then data, dly cycles in EXEC, then exec_done.
  task automatic step(input int lat, input logic [31:0] w, input int dly,
                      input bit br, input logic [1:0] bt, input bit j, input bit z, input bit s);
    for (int i = 0; i < lat; i++) begin
      imem_valid_i = 1'b0; imem_rdata_i = $urandom;
      exec_done_i  = 1'($urandom); rnd_ctl();
      tick();
    end
    imem_valid_i = 1'b1; imem_rdata_i = w; exec_done_i = 1'($urandom); rnd_ctl();
    tick();
    exp_instr = w; exp_valid = 1'b1; exp_req = 1'b0;
    for (int i = 0; i < dly; i++) begin
      imem_valid_i = 1'($urandom); imem_rdata_i = $urandom;
      exec_done_i  = 1'b0; rnd_ctl();
      tick();
    end
    imem_valid_i = 1'($urandom); imem_rdata_i = $urandom;
    exec_done_i = 1'b1; branch_i = br; branch_type_i = bt; jump_i = j; zero_i = z; sign_i = s;
    tick();
    exp_pc = model_next(exp_pc, w, br, bt, j, z, s);
    exp_valid = 1'b0; exp_req = 1'b1;
    exec_done_i = 1'b0; imem_valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0; imem_valid_i = 1'b0; imem_rdata_i = 32'h0; exec_done_i = 1'b0;
    branch_i = 1'b0; branch_type_i = 2'd0; jump_i = 1'b0; zero_i = 1'b0; sign_i = 1'b0;
    reset_exp();
    tick();
    chk_en = 1'b1;
    tick();
    rst_i = 1'b1;
    tick();
    exp_req = 1'b1;

    step(3, 32'h2000_0001, 1, 0, 2'd0, 0, 0, 0);
    chk("seq_pc1", pc_o, 32'h4);
    step(3, 32'h2000_0002, 1, 0, 2'd0, 0, 0, 0);
    chk("seq_pc2", pc_o, 32'h8);
    step(2, 32'h0800_0040, 0, 1, 2'd0, 1, 1, 0);
    chk("jump_over_branch", pc_o, 32'h100);
    step(1, 32'h1000_FFC3, 2, 1, 2'd0, 0, 1, 0);
    chk("beq_back", pc_o, 32'h10);
    step(0, 32'h1000_FFFE, 1, 1, 2'd0, 0, 1, 0);
    chk("beq_taken", pc_o, 32'h0C);
    step(4, 32'h1000_FFFE, 1, 1, 2'd0, 0, 0, 0);
    chk("beq_not_taken", pc_o, 32'h10);
    step(1, 32'h1400_FFFA, 0, 1, 2'd3, 0, 0, 0);
    chk("bne_to_top", pc_o, 32'hFFFF_FFFC);
    chk("plus4_wrap", pc_plus4_o, 32'h0);
    step(TMO - 1, 32'h2000_0003, 1, 0, 2'd0, 0, 0, 0);
    chk("seq_wrap", pc_o, 32'h0);
    step(2, 32'h1C00_0010, 1, 1, 2'd1, 0, 0, 0);
    chk("bgt_taken", pc_o, 32'h44);
    step(2, 32'h1800_0004, 1, 1, 2'd2, 0, 0, 1);
    chk("ble_taken", pc_o, 32'h58);

    for (int n = 0; n < 60; n++)
      step(int'($urandom_range(0, 6)), $urandom, int'($urandom_range(0, 3)),
           1'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0),
           1'($urandom), 1'($urandom));

    // Timeout: just short of the limit nothing happens, on the limit the error latches.
    for (int i = 0; i < int'(TMO) - 1; i++) begin
      imem_valid_i = 1'b0; exec_done_i = 1'($urandom); rnd_ctl();
      tick();
    end
    chk("no_err_before_limit", 32'(fetch_err_o), 32'h0);
    tick();
    exp_err = 1'b1;
    chk("err_at_limit", 32'(fetch_err_o), 32'h1);
    for (int i = 0; i < 6; i++) begin
      imem_valid_i = 1'b1; imem_rdata_i = $urandom; exec_done_i = 1'b1; rnd_ctl();
      tick();
    end
    chk("err_sticky", 32'(fetch_err_o), 32'h1);
    imem_valid_i = 1'b0; exec_done_i = 1'b0;

    rst_i = 1'b0;
    tick();
    reset_exp();
    rst_i = 1'b1; imem_valid_i = 1'b1; imem_rdata_i = 32'hCAFE_0000;
    tick();
    exp_req = 1'b1;
    imem_valid_i = 1'b0;
    step(1, 32'h1234_5678, 1, 0, 2'd0, 0, 0, 0);
    chk("after_halt_reset_pc", pc_o, 32'h4);

    // Reset in the middle of a fetch, with the late response arriving after it.
    imem_valid_i = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();
    reset_exp();
    rst_i = 1'b1; imem_valid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    tick();
    exp_req = 1'b1;
    chk("late_valid_instr", instr_o, 32'h0);
    chk("late_valid_pc", pc_o, 32'h0);
    imem_valid_i = 1'b0;
    step(2, 32'h0800_0123, 1, 0, 2'd0, 1, 0, 0);
    chk("post_reset_jump", pc_o, 32'h48C);

    tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
